// File: rtl/mem_loader.sv
// Program-memory loader: streams words into a memory region, reads the region back,
// compares checksums, and releases the CPU reset only after a clean verify.
module mem_loader #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] mem,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_rst_n
);

  localparam logic [ADDR_WIDTH:0] MaxCount = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {StIdle, StWrite, StVerify, StCheck, StDone, StError} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wr_sum_q, wr_sum_d;
  logic [DATA_WIDTH-1:0] rd_sum_q, rd_sum_d;
  logic [1:0]            pipe_q, pipe_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  cpu_rst_n_q, cpu_rst_n_d;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  last;

  assign cur_addr = base_q + idx_q[ADDR_WIDTH-1:0];
  assign last     = (idx_q == count_q - 1'b1);
  assign in_ready = (state_q == StWrite);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    idx_d       = idx_q;
    wr_sum_d    = wr_sum_q;
    // Read data lands two edges after its address was registered.
    pipe_d      = {pipe_q[0], 1'b0};
    rd_sum_d    = pipe_q[1] ? rd_sum_q + mem : rd_sum_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    cpu_rst_n_d = cpu_rst_n_q;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          cpu_rst_n_d = 1'b0;
          if (count == '0 || count > MaxCount) begin
            state_d = StError;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            state_d  = StWrite;
            base_d   = base_addr;
            count_d  = count;
            idx_d    = '0;
            wr_sum_d = '0;
            rd_sum_d = '0;
            pipe_d   = '0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            error_d  = 1'b0;
          end
        end
      end
      StWrite: begin
        if (in_valid && in_ready) begin
          we_d     = 1'b1;
          addr_d   = cur_addr;
          data_d   = in_data;
          wr_sum_d = wr_sum_q + in_data;
          if (last) begin
            idx_d   = '0;
            state_d = StVerify;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StVerify: begin
        addr_d    = cur_addr;
        pipe_d[0] = 1'b1;
        idx_d     = idx_q + 1'b1;
        if (last) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (pipe_q == 2'b00) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          if (rd_sum_q == wr_sum_q) begin
            cpu_rst_n_d = 1'b1;
            state_d     = StDone;
          end else begin
            error_d = 1'b1;
            state_d = StError;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      wr_sum_q    <= '0;
      rd_sum_q    <= '0;
      pipe_q      <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      wr_sum_q    <= wr_sum_d;
      rd_sum_q    <= rd_sum_d;
      pipe_q      <= pipe_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign we        = we_q;
  assign addr      = addr_q;
  assign data      = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: table of load scenarios plus reset, bad-count and abort
// sequences, against a 64x16 registered-read memory model.
module tb_mem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  base_addr;
  logic [6:0]  count;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [15:0] mem_rd;
  logic        we;
  logic [5:0]  addr;
  logic [15:0] data;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_rst_n;

  int errors = 0;
  int checks = 0;
  bit corrupt = 1'b0;
  logic [15:0] mem_arr [64];

  mem_loader #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem       (mem_rd),
    .we        (we),
    .addr      (addr),
    .data      (data),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cpu_rst_n (cpu_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model; when corrupt is set, reads of address 9 return zero.
  always @(posedge clk) begin
    if (we === 1'b1) mem_arr[addr] <= data;
    mem_rd <= (corrupt && addr == 6'd9) ? 16'h0000 : mem_arr[addr];
  end

  typedef struct packed {
    logic [5:0]       base;
    logic [6:0]       cnt;
    logic             gap;
    logic             corrupt;
    logic             mid_start;
    logic             exp_err;
    logic             exp_cpu;
    logic [3:0][15:0] words;
    logic [3:0][5:0]  exp_addr;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(input logic [5:0] b, input logic [6:0] n, input logic gp,
                              input logic cr, input logic ms, input logic ee, input logic ec,
                              input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3,
                              input logic [5:0] a0, input logic [5:0] a1,
                              input logic [5:0] a2, input logic [5:0] a3);
    vec_t v;
    v.base = b; v.cnt = n; v.gap = gp; v.corrupt = cr; v.mid_start = ms;
    v.exp_err = ee; v.exp_cpu = ec;
    v.words[0] = w0; v.words[1] = w1; v.words[2] = w2; v.words[3] = w3;
    v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2; v.exp_addr[3] = a3;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int nw, nr, cyc, widx, terr;
    bit hs;
    logic [5:0]  wa [4];
    logic [15:0] wd [4];
    logic [5:0]  ra [4];
    corrupt   = v.corrupt;
    base_addr = v.base;
    count     = v.cnt;
    start     = 1'b1;
    step();
    start = 1'b0;
    nw = 0; nr = 0; cyc = 0; widx = 0; terr = 0;
    while (done !== 1'b1 && cyc < 40) begin
      in_valid = v.gap ? (cyc % 2 == 1) : 1'b1;
      in_data  = (widx < int'(v.cnt)) ? v.words[widx % 4] : 16'hDEAD;
      if (v.mid_start && cyc == 2) begin
        start = 1'b1; base_addr = 6'd30; count = 7'd1;
      end
      hs = in_valid && in_ready;
      step();
      start = 1'b0;
      cyc++;
      if (hs) widx++;
      if (we !== hs) terr++;
      if (we === 1'b1) begin
        if (nw < 4) begin wa[nw] = addr; wd[nw] = data; end
        nw++;
      end else if (nw == int'(v.cnt) && nr < int'(v.cnt) && busy === 1'b1) begin
        ra[nr] = addr;
        nr++;
      end
    end
    in_valid = 1'b0;
    check($sformatf("v%0d done", k), 32'(done), 32'd1);
    check($sformatf("v%0d write_count", k), 32'(nw), 32'(v.cnt));
    check($sformatf("v%0d write_timing", k), 32'(terr), 32'd0);
    for (int i = 0; i < int'(v.cnt) && i < 4; i++) begin
      check($sformatf("v%0d wr_addr%0d", k, i), 32'(wa[i]), 32'(v.exp_addr[i]));
      check($sformatf("v%0d wr_data%0d", k, i), 32'(wd[i]), 32'(v.words[i]));
      check($sformatf("v%0d rd_addr%0d", k, i), 32'(ra[i]), 32'(v.exp_addr[i]));
      check($sformatf("v%0d mem%0d", k, i), 32'(mem_arr[v.exp_addr[i]]), 32'(v.words[i]));
    end
    check($sformatf("v%0d error", k), 32'(error), 32'(v.exp_err));
    check($sformatf("v%0d cpu_rst_n", k), 32'(cpu_rst_n), 32'(v.exp_cpu));
    check($sformatf("v%0d busy", k), 32'(busy), 32'd0);
    if (!v.gap)
      check($sformatf("v%0d latency_ok", k), 32'(cyc <= 2 * int'(v.cnt) + 6), 32'd1);
    step();
    step();
    check($sformatf("v%0d done_sticky", k), 32'(done), 32'd1);
    check($sformatf("v%0d we_idle", k), 32'(we), 32'd0);
    corrupt = 1'b0;
  endtask

  initial begin
    int wcount;
    for (int i = 0; i < 64; i++) mem_arr[i] = 16'h0000;
    vecs[0] = mk(6'd8, 7'd4, 0, 0, 0, 0, 1, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
                 6'd8, 6'd9, 6'd10, 6'd11);
    vecs[1] = mk(6'd0, 7'd3, 1, 0, 0, 0, 1, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0000,
                 6'd0, 6'd1, 6'd2, 6'd0);
    vecs[2] = mk(6'd62, 7'd4, 0, 0, 0, 0, 1, 16'h000A, 16'h000B, 16'h000C, 16'h000D,
                 6'd62, 6'd63, 6'd0, 6'd1);
    vecs[3] = mk(6'd8, 7'd2, 0, 1, 0, 1, 0, 16'h1234, 16'h5678, 16'h0000, 16'h0000,
                 6'd8, 6'd9, 6'd0, 6'd0);
    vecs[4] = mk(6'd40, 7'd3, 0, 0, 0, 0, 1, 16'hFFFF, 16'h8001, 16'h7FFF, 16'h0000,
                 6'd40, 6'd41, 6'd42, 6'd0);
    vecs[5] = mk(6'd20, 7'd4, 0, 0, 1, 0, 1, 16'h0101, 16'h0202, 16'h0303, 16'h0404,
                 6'd20, 6'd21, 6'd22, 6'd23);

    // Reset with start and valid asserted.
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF;
    base_addr = 6'd8; count = 7'd4;
    wcount = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (we === 1'b1) wcount++;
    end
    check("rst we_pulses", 32'(wcount), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst error", 32'(error), 32'd0);
    check("rst cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst addr", 32'(addr), 32'd0);
    check("rst data", 32'(data), 32'd0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    step();

    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

    // Illegal counts.
    count = 7'd0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("cnt0 error", 32'(error), 32'd1);
    check("cnt0 done", 32'(done), 32'd1);
    check("cnt0 busy", 32'(busy), 32'd0);
    check("cnt0 cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("cnt0 in_ready", 32'(in_ready), 32'd0);
    count = 7'd65; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("cnt65 error", 32'(error), 32'd1);
    check("cnt65 busy", 32'(busy), 32'd0);

    // Recovery from ERROR with a good load.
    run_vec(6, vecs[0]);

    // Abort after two of four words.
    base_addr = 6'd50; count = 7'd4; start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'hAAA0;
    step();
    in_data = 16'hAAA1;
    step();
    rst = 1'b1; in_data = 16'hAAA2;
    step();
    rst = 1'b0;
    check("abort we", 32'(we), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("abort addr", 32'(addr), 32'd0);
    wcount = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (we === 1'b1) wcount++;
    end
    in_valid = 1'b0;
    check("abort we_pulses", 32'(wcount), 32'd0);
    check("abort mem50", 32'(mem_arr[50]), 32'h0000AAA0);
    check("abort mem52", 32'(mem_arr[52]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
